// File: rtl/lamp_fpu_round_pkg.sv
// Shared floating-point constants, rounding-mode encoding and the
// round-increment helper used by the bfloat16 round/pack stage.
package lampFPU_pkg;

    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_FLOAT_DW   = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

    // All-ones biased exponent encodes Inf/NaN.
    localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_FLOAT_E_MAX = '1;

    // Bit positions inside the 3-bit {OF,UF,NX} flag vector.
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_mode_t;

    // Decide whether the truncated significand must be bumped by one ulp.
    // Unknown mode encodings fall back to round-to-nearest-even.
    function automatic logic FUNC_rndInc(
        input logic [2:0] mode,
        input logic       s,
        input logic       lsb,
        input logic       g,
        input logic       st
    );
        logic inexact;
        inexact = g | st;
        case (mode)
            RTZ:     FUNC_rndInc = 1'b0;
            RDN:     FUNC_rndInc = inexact & s;
            RUP:     FUNC_rndInc = inexact & ~s;
            RMM:     FUNC_rndInc = g;
            default: FUNC_rndInc = g & (st | lsb);
        endcase
    endfunction

endpackage

// File: rtl/lamp_fpu_round.sv
// Two-stage round/pack for bfloat16 results coming out of add/sub
// normalisation: stage 1 decides the increment, stage 2 applies it,
// handles carry/denormal promotion/overflow and packs the word.
module lamp_fpu_round
    import lampFPU_pkg::*;
#(
    parameter int E_DW = LAMP_FLOAT_E_DW,
    parameter int F_DW = LAMP_FLOAT_F_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               doRound_i,
    input  logic [2:0]         rndMode_i,
    input  logic               s_res_i,
    input  logic [E_DW-1:0]    e_res_i,
    input  logic [F_DW+4:0]    f_res_i,
    input  logic               isOverflow_i,
    input  logic               isUnderflow_i,
    input  logic               isToRound_i,
    input  logic               clrFlags_i,
    output logic [E_DW+F_DW:0] result_o,
    output logic               valid_o,
    output logic [2:0]         flags_o,
    output logic [2:0]         flagsAcc_o
);

    localparam logic [E_DW-1:0] E_MAX    = '1;
    localparam logic [E_DW-1:0] E_MAX_M1 = {{(E_DW-1){1'b1}}, 1'b0};
    localparam logic [E_DW-1:0] E_ONE    = {{(E_DW-1){1'b0}}, 1'b1};

    // The overflow bit of the extended significand is always 0 for valid ops.
    logic w_unused_ovf_bit;
    assign w_unused_ovf_bit = f_res_i[F_DW+4];

    // Stage-1 state
    logic            r_s, r_inc, r_inexact, r_ovf, r_unf, r_to_round, r_valid;
    logic [E_DW-1:0] r_e;
    logic [F_DW:0]   r_mant;
    logic [2:0]      r_mode;

    // Stage-2 / output state
    logic [E_DW+F_DW:0] r_result;
    logic               r_valid_out;
    logic [2:0]         r_flags, r_flags_acc;

    logic w_inc_next, w_inexact_next;

    logic [F_DW+1:0]    w_sum;
    logic               w_carry;
    logic [E_DW-1:0]    w_e_inc, w_e_fin;
    logic [F_DW-1:0]    w_f_fin;
    logic               w_ovf, w_inf;
    logic [E_DW+F_DW:0] w_result_next;
    logic [2:0]         w_flags_next, w_flags_acc_next;

    // Stage-1 rounding decision; pass-through ops never increment.
    always_comb begin
        w_inexact_next = f_res_i[2] | f_res_i[1] | f_res_i[0];
        w_inc_next     = isToRound_i &
                         FUNC_rndInc(rndMode_i, s_res_i, f_res_i[3], f_res_i[2],
                                     f_res_i[1] | f_res_i[0]);
    end

    assign w_sum   = {1'b0, r_mant} + {{(F_DW+1){1'b0}}, r_inc};
    assign w_carry = w_sum[F_DW+1];
    assign w_e_inc = r_e + E_ONE;

    // Stage-2 increment, renormalise, overflow saturation and flag generation.
    always_comb begin
        w_e_fin       = r_e;
        w_f_fin       = w_sum[F_DW-1:0];
        w_result_next = '0;
        w_flags_next  = '0;
        if (w_carry) begin
            w_e_fin = w_e_inc;
            w_f_fin = '0;
        end else if (r_e == '0 && w_sum[F_DW]) begin
            w_e_fin = E_ONE;
        end
        w_ovf = r_ovf | (w_carry & (w_e_inc == E_MAX));
        // Only the modes that round away from the overflowing side saturate.
        w_inf = !((r_mode == RTZ) || (r_mode == RUP && r_s) || (r_mode == RDN && !r_s));
        if (r_valid) begin
            if (!r_to_round) begin
                w_result_next = {r_s, r_e, r_mant[F_DW-1:0]};
            end else if (w_ovf) begin
                w_result_next         = w_inf ? {r_s, E_MAX, {F_DW{1'b0}}}
                                              : {r_s, E_MAX_M1, {F_DW{1'b1}}};
                w_flags_next[FLAG_OF] = 1'b1;
                w_flags_next[FLAG_UF] = r_unf;
                w_flags_next[FLAG_NX] = 1'b1;
            end else begin
                w_result_next         = {r_s, w_e_fin, w_f_fin};
                w_flags_next[FLAG_UF] = r_unf | ((w_e_fin == '0) & r_inexact);
                w_flags_next[FLAG_NX] = r_inexact;
            end
        end
        // New flags are ORed after the clear so they survive a same-cycle clear.
        w_flags_acc_next = (clrFlags_i ? 3'b000 : r_flags_acc) | w_flags_next;
    end

    // Pipeline registers for both stages plus the sticky flag accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s         <= 1'b0;
            r_e         <= '0;
            r_mant      <= '0;
            r_inc       <= 1'b0;
            r_inexact   <= 1'b0;
            r_mode      <= 3'd0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_to_round  <= 1'b0;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_valid_out <= 1'b0;
            r_flags     <= 3'b000;
            r_flags_acc <= 3'b000;
        end else begin
            r_s         <= s_res_i;
            r_e         <= e_res_i;
            r_mant      <= f_res_i[F_DW+3:3];
            r_inc       <= w_inc_next;
            r_inexact   <= w_inexact_next;
            r_mode      <= rndMode_i;
            r_ovf       <= isOverflow_i;
            r_unf       <= isUnderflow_i;
            r_to_round  <= isToRound_i;
            r_valid     <= doRound_i;
            r_result    <= w_result_next;
            r_valid_out <= r_valid;
            r_flags     <= w_flags_next;
            r_flags_acc <= w_flags_acc_next;
        end
    end

    assign result_o   = r_result;
    assign valid_o    = r_valid_out;
    assign flags_o    = r_flags;
    assign flagsAcc_o = r_flags_acc;

endmodule

// File: tb/tb_lamp_fpu_round.sv
// Directed self-checking bench for the bfloat16 round/pack stage.
module tb_lamp_fpu_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        doRound_i;
    logic [2:0]  rndMode_i;
    logic        s_res_i;
    logic [7:0]  e_res_i;
    logic [11:0] f_res_i;
    logic        isOverflow_i, isUnderflow_i, isToRound_i, clrFlags_i;
    logic [15:0] result_o;
    logic        valid_o;
    logic [2:0]  flags_o, flagsAcc_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lamp_fpu_round dut (
        .clk          (clk),
        .rst          (rst),
        .doRound_i    (doRound_i),
        .rndMode_i    (rndMode_i),
        .s_res_i      (s_res_i),
        .e_res_i      (e_res_i),
        .f_res_i      (f_res_i),
        .isOverflow_i (isOverflow_i),
        .isUnderflow_i(isUnderflow_i),
        .isToRound_i  (isToRound_i),
        .clrFlags_i   (clrFlags_i),
        .result_o     (result_o),
        .valid_o      (valid_o),
        .flags_o      (flags_o),
        .flagsAcc_o   (flagsAcc_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op on the inputs (does not advance time).
    task automatic set_op(input logic [2:0] mode, input logic s, input logic [7:0] e,
                          input logic hid, input logic [6:0] frac, input logic [2:0] grs,
                          input logic ovf, input logic unf, input logic to_round);
        doRound_i     = 1'b1;
        rndMode_i     = mode;
        s_res_i       = s;
        e_res_i       = e;
        f_res_i       = {1'b0, hid, frac, grs};
        isOverflow_i  = ovf;
        isUnderflow_i = unf;
        isToRound_i   = to_round;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op through the pipe, then check the result two cycles later.
    task automatic run_op(input string tag, input logic [2:0] mode, input logic s,
                          input logic [7:0] e, input logic hid, input logic [6:0] frac,
                          input logic [2:0] grs, input logic ovf, input logic to_round,
                          input logic [15:0] exp_res, input logic [2:0] exp_flags);
        set_op(mode, s, e, hid, frac, grs, ovf, 1'b0, to_round);
        step();
        doRound_i = 1'b0;
        step();
        chk({tag, "_res"}, result_o, exp_res);
        chk({tag, "_flags"}, {13'd0, flags_o}, {13'd0, exp_flags});
        chk({tag, "_valid"}, {15'd0, valid_o}, 16'd1);
        $display("op %s: result=%h flags=%b valid=%b", tag, result_o, flags_o, valid_o);
    endtask

    initial begin
        rst = 1'b1; doRound_i = 1'b0; rndMode_i = 3'd0; s_res_i = 1'b0; e_res_i = 8'h00;
        f_res_i = 12'h000; isOverflow_i = 1'b0; isUnderflow_i = 1'b0; isToRound_i = 1'b1;
        clrFlags_i = 1'b0;
        step(); step();
        chk("rst_valid", {15'd0, valid_o}, 16'd0);
        chk("rst_result", result_o, 16'h0000);
        chk("rst_flags", {13'd0, flags_o}, 16'd0);
        chk("rst_acc", {13'd0, flagsAcc_o}, 16'd0);
        rst = 1'b0;
        step();

        //      tag         mode s  e      h  frac   GRS     ovf  tr    result    flags
        run_op("tie_even",  3'd0, 0, 8'h7F, 1, 7'h00, 3'b100, 0,  1, 16'h3F80, 3'b001);
        run_op("tie_odd",   3'd0, 0, 8'h7F, 1, 7'h01, 3'b100, 0,  1, 16'h3F82, 3'b001);
        run_op("tie_rtz",   3'd1, 0, 8'h7F, 1, 7'h01, 3'b100, 0,  1, 16'h3F81, 3'b001);
        run_op("rmm",       3'd4, 0, 8'h7F, 1, 7'h01, 3'b100, 0,  1, 16'h3F82, 3'b001);
        run_op("rdn_neg",   3'd2, 1, 8'h7F, 1, 7'h01, 3'b001, 0,  1, 16'hBF82, 3'b001);
        run_op("rup_pos",   3'd3, 0, 8'h7F, 1, 7'h01, 3'b010, 0,  1, 16'h3F82, 3'b001);
        run_op("carry",     3'd0, 0, 8'h7E, 1, 7'h7F, 3'b100, 0,  1, 16'h3F80, 3'b001);
        run_op("ovf_rne",   3'd0, 0, 8'hFE, 1, 7'h7F, 3'b100, 0,  1, 16'h7F80, 3'b101);
        run_op("ovf_rtz",   3'd1, 0, 8'hFE, 1, 7'h7F, 3'b100, 1,  1, 16'h7F7F, 3'b101);
        run_op("ovf_rup_n", 3'd3, 1, 8'hFE, 1, 7'h7F, 3'b100, 1,  1, 16'hFF7F, 3'b101);
        run_op("den_prom",  3'd0, 0, 8'h00, 0, 7'h7F, 3'b100, 0,  1, 16'h0080, 3'b001);
        run_op("den_exact", 3'd0, 0, 8'h00, 0, 7'h01, 3'b000, 0,  1, 16'h0001, 3'b000);
        run_op("den_uf",    3'd1, 0, 8'h00, 0, 7'h10, 3'b100, 0,  1, 16'h0010, 3'b011);
        run_op("neg_zero",  3'd0, 1, 8'h00, 0, 7'h00, 3'b000, 0,  1, 16'h8000, 3'b000);
        run_op("passthru",  3'd0, 0, 8'hFF, 1, 7'h40, 3'b111, 0,  0, 16'h7FC0, 3'b000);

        // Idle cycle: no valid, flags and result zero.
        step();
        chk("idle_valid", {15'd0, valid_o}, 16'd0);
        chk("idle_result", result_o, 16'h0000);
        chk("idle_flags", {13'd0, flags_o}, 16'd0);

        // Clear the accumulator, then two back-to-back ops accumulate.
        clrFlags_i = 1'b1;
        step();
        clrFlags_i = 1'b0;
        chk("clr_acc", {13'd0, flagsAcc_o}, 16'd0);
        set_op(3'd1, 1'b0, 8'h00, 1'b0, 7'h10, 3'b100, 1'b0, 1'b0, 1'b1);
        step();
        set_op(3'd0, 1'b0, 8'hFE, 1'b1, 7'h7F, 3'b100, 1'b0, 1'b0, 1'b1);
        step();
        doRound_i = 1'b0;
        chk("b2b_1_flags", {13'd0, flags_o}, 16'h0003);
        chk("b2b_1_acc", {13'd0, flagsAcc_o}, 16'h0003);
        $display("b2b op1: flags=%b acc=%b", flags_o, flagsAcc_o);
        step();
        chk("b2b_2_res", result_o, 16'h7F80);
        chk("b2b_2_acc", {13'd0, flagsAcc_o}, 16'h0007);
        $display("b2b op2: result=%h flags=%b acc=%b", result_o, flags_o, flagsAcc_o);

        // Clear held across an NX-only op: only NX remains.
        clrFlags_i = 1'b1;
        set_op(3'd0, 1'b0, 8'h7F, 1'b1, 7'h00, 3'b100, 1'b0, 1'b0, 1'b1);
        step();
        doRound_i = 1'b0;
        step();
        clrFlags_i = 1'b0;
        chk("clr_nx_flags", {13'd0, flags_o}, 16'h0001);
        chk("clr_nx_acc", {13'd0, flagsAcc_o}, 16'h0001);
        $display("clr+nx: flags=%b acc=%b", flags_o, flagsAcc_o);

        // Reset one cycle after issue discards the op.
        set_op(3'd0, 1'b0, 8'hFE, 1'b1, 7'h7F, 3'b100, 1'b0, 1'b0, 1'b1);
        step();
        doRound_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_fl_valid", {15'd0, valid_o}, 16'd0);
        chk("rst_fl_acc", {13'd0, flagsAcc_o}, 16'd0);
        step();
        chk("rst_fl_valid2", {15'd0, valid_o}, 16'd0);
        chk("rst_fl_acc2", {13'd0, flagsAcc_o}, 16'd0);
        $display("rst inflight: valid=%b acc=%b", valid_o, flagsAcc_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
